// File: rtl/instr_fetch_pkg.sv
// Shared defaults for the fetch path (pointer, fetch stage and decoder agree on widths).
// Also holds the sizing helper used for occupancy counters.
package instr_fetch_pkg;

    localparam int ADDR_WIDTH_DEF  = 8;
    localparam int INSTR_WIDTH_DEF = 32;
    localparam int FIFO_DEPTH_DEF  = 2;

    // Width of a counter that must hold every value 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {addr, instr} entries feeding the decoder.
// clear drops all entries at the next edge and dominates push/pop.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int WIDTH = ADDR_WIDTH_DEF + INSTR_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop && (count != '0);

    // NOTE: storage carries no reset; dout is masked while empty, so stale words never escape.
    always_ff @(posedge clk) begin
        if (push) begin
            storage[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (do_pop) rd_ptr <= bump(rd_ptr);
            if (push && !do_pop) count <= count + 1'b1;
            else if (!push && do_pop) count <= count - 1'b1;
        end
    end

    assign dout = (count != '0) ? storage[rd_ptr] : '0;

    // Upstream credit accounting must never push into a full buffer.
    no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !do_pop && !clear && count == CW'(DEPTH)));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues one memory read per credit, buffers returns, and hands them to the decoder.
// Credits = FIFO_DEPTH minus (buffered + in-flight); a same-cycle pop frees a credit immediately.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               flush,
    input  logic [ADDR_WIDTH-1:0]              ptr_in,
    output logic                               ptr_advance,
    output logic                               mem_ren,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    input  logic [INSTR_WIDTH-1:0]             mem_rdata,
    output logic [INSTR_WIDTH-1:0]             instr_out,
    output logic [ADDR_WIDTH-1:0]              instr_addr,
    output logic                               instr_valid,
    input  logic                               instr_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int CW = count_width(FIFO_DEPTH);

    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_addr;
    logic [CW:0]           occupancy;
    logic                  pop;
    logic                  push;
    logic                  issue;

    assign pop       = instr_valid && instr_ready;
    assign occupancy = {1'b0, fifo_count} + (CW + 1)'(inflight);

    // Gating with reset keeps the read strobe low the moment reset asserts, not an edge later.
    assign issue = reset && enable && !flush &&
                   ((occupancy < (CW + 1)'(FIFO_DEPTH)) ||
                    ((occupancy == (CW + 1)'(FIFO_DEPTH)) && pop));

    assign mem_ren     = issue;
    assign ptr_advance = issue;
    assign mem_addr    = ptr_in;

    // A flush kills the return that is on the memory bus this cycle.
    assign push = inflight && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else begin
            inflight <= issue;
            if (issue) inflight_addr <= ptr_in;
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_WIDTH + INSTR_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   ({inflight_addr, mem_rdata}),
        .dout  ({instr_addr, instr_out}),
        .count (fifo_count)
    );

    assign instr_valid = (fifo_count != '0);

endmodule
